// File: rtl/sdram_pll_lock_sequencer.sv
// SDRAM PLL supervisor: sequences PLL reset, waits for stable lock, then releases the system reset.
// Optional macro SDRAM_PLL_LOSS_COUNT_EN adds a saturating lock-loss counter output.
module sdram_pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 500000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
`ifdef SDRAM_PLL_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam logic [2:0] ST_PLL_RESET = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABILIZE = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    logic             sync_q;
    logic             locked_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       state_d;
    logic [3:0]       retry_d;
    logic             pll_rst_d;
    logic             sys_reset_n_d;
    logic             ready_d;
    logic             fail_d;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= pll_locked;
            locked_s <= sync_q;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PLL_RESET;
            cnt_q       <= '0;
            retry_cnt   <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt   <= retry_d;
            pll_rst     <= pll_rst_d;
            sys_reset_n <= sys_reset_n_d;
            ready       <= ready_d;
            fail        <= fail_d;
        end
    end

    // Next-state logic; outputs follow the next state so they move with it
    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        retry_d = retry_cnt;

        if (restart_req && (state != ST_PLL_RESET)) begin
            state_d = ST_PLL_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state)
                ST_PLL_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_cnt == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_PLL_RESET;
                            retry_d = retry_cnt + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABILIZE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_PLL_RESET;
                        cnt_d   = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_PLL_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end

        pll_rst_d     = (state_d == ST_PLL_RESET);
        sys_reset_n_d = (state_d == ST_RUN);
        ready_d       = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

`ifdef SDRAM_PLL_LOSS_COUNT_EN
    // Counts only lock-loss exits from RUN; restart_req takes priority and is not counted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_cnt <= '0;
        end else if ((state == ST_RUN) && !locked_s && !restart_req
                     && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_pll_lock_sequencer.sv
// Directed self-checking bench for sdram_pll_lock_sequencer (RST=4, TIMEOUT=32, STABLE=8, RETRIES=2).
module tb_sdram_pll_lock_sequencer;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;
`ifdef SDRAM_PLL_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    sdram_pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .restart_req(restart_req),
        .pll_rst    (pll_rst),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fail       (fail),
        .state      (state),
        .retry_cnt  (retry_cnt)
`ifdef SDRAM_PLL_LOSS_COUNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic prst,
                           input logic sysn, input logic rdy, input logic fl,
                           input logic [3:0] rc);
        check({tag, ".state"},       32'(state),       32'(st));
        check({tag, ".pll_rst"},     32'(pll_rst),     32'(prst));
        check({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(sysn));
        check({tag, ".ready"},       32'(ready),       32'(rdy));
        check({tag, ".fail"},        32'(fail),        32'(fl));
        check({tag, ".retry_cnt"},   32'(retry_cnt),   32'(rc));
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while ((state !== st) && (n < budget)) begin
            step(1);
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    task automatic chk_loss(input string tag, input int exp);
`ifdef SDRAM_PLL_LOSS_COUNT_EN
        check(tag, 32'(lock_loss_cnt), 32'(exp));
`else
        if (tag.len() < 0) $display("%0d", exp);
`endif
    endtask

    initial begin
        reset_n     = 1'b0;
        pll_locked  = 1'b1;
        restart_req = 1'b0;
        step(3);
        chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk_loss("reset.loss", 0);

        // 1. Nominal start with lock present from time 0
        reset_n = 1'b1;
        step(3);
        chk_all("t1_prst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t1_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t1_stab", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(7);
        chk_all("t1_stab_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t1_run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // 4. Lock loss in RUN: reacts exactly 3 clk after the drop
        pll_locked = 1'b0;
        step(2);
        chk_all("t4_hold", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1);
        chk_all("t4_drop", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk_loss("t4_loss", 1);
        pll_locked = 1'b1;
        wait_state("t4_reseq", 3'd3, 40);
        chk_all("t4_run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // 2. Lock timeout, retries, FAIL, restart
        pll_locked = 1'b0;
        step(3);
        chk_all("t2_loss", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk_loss("t2_loss_cnt", 2);
        wait_state("t2_wait1_enter", 3'd1, 10);
        step(31);
        chk_all("t2_wait1_end", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t2_retry1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        step(3);
        chk_all("t2_retry1_prst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1);
        chk_all("t2_wait2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        step(31);
        chk_all("t2_wait2_end", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1);
        chk_all("t2_retry2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        step(4);
        chk_all("t2_wait3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        step(32);
        chk_all("t2_fail", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        step(5);
        chk_all("t2_fail_hold", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        restart_req = 1'b1;
        step(1);
        restart_req = 1'b0;
        chk_all("t2_restart", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // 3. Unstable lock: 5 good cycles in STABILIZE then drop
        wait_state("t3_wait_enter", 3'd1, 10);
        pll_locked = 1'b1;
        step(3);
        chk_all("t3_stab", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(3);
        pll_locked = 1'b0;
        step(2);
        chk_all("t3_stab_hold", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t3_back", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        pll_locked = 1'b1;
        step(3);
        chk_all("t3_stab2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(7);
        chk_all("t3_stab2_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t3_run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // 5a. restart_req from RUN, then colliding with STABILIZE completion
        restart_req = 1'b1;
        step(1);
        restart_req = 1'b0;
        chk_all("t5_restart_run", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk_loss("t5_loss_unchanged", 2);
        step(3);
        chk_all("t5_prst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t5_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        chk_all("t5_stab", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(7);
        chk_all("t5_stab_last", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        restart_req = 1'b1;
        step(1);
        restart_req = 1'b0;
        chk_all("t5_prio", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // restart_req inside PLL_RESET must not extend the reset window
        step(1);
        restart_req = 1'b1;
        step(1);
        restart_req = 1'b0;
        chk_all("t5_ign_prst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(2);
        chk_all("t5_ign_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_state("t5_run_enter", 3'd3, 20);
        chk_all("t5_run", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // 5b. Asynchronous reset in RUN, checked before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("t5_async", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk_loss("t5_async_loss", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
